counter_cmd_seq: RTL and testbench

//  Command sequencer directly upstream of the 4-bit load/inc/dec/shift/wrap counter.

---
 rtl/counter_cmd_pkg.sv | 17 +
 rtl/counter_cmd_slot.sv | 34 +++
 rtl/counter_cmd_seq.sv | 148 ++++++++++++++
 tb/tb_counter_cmd_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_cmd_pkg.sv
// Shared opcode values and FSM state type for the counter command sequencer.
package counter_cmd_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic is_strobe_op(input logic [2:0] op);
    return (op >= OP_LOAD) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/counter_cmd_slot.sv
// One-entry holding register for a command accepted while the sequencer is busy.
module counter_cmd_slot #(
  parameter int DW = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          rd,
  input  logic [2:0]    op_in,
  input  logic [DW-1:0] d_in,
  input  logic [CW-1:0] n_in,
  output logic          vld,
  output logic [2:0]    op,
  output logic [DW-1:0] d,
  output logic [CW-1:0] n
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     vld <= 1'b0;
    else if (wr) vld <= 1'b1;
    else if (rd) vld <= 1'b0;
  end

  // Payload is only meaningful while vld is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr) begin
      op <= op_in;
      d  <= d_in;
      n  <= n_in;
    end
  end

endmodule

// File: rtl/counter_cmd_seq.sv
// Command sequencer driving the load/inc/dec/shift counter strobes.
// Optional one-entry command queue: define COUNTER_CMD_SEQ_QUEUE_EN.
module counter_cmd_seq
  import counter_cmd_pkg::*;
#(
  parameter int DW = 4,
  parameter int CW = 4
) (
  input  logic          C,
  input  logic          R,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic [2:0]    CMD_OP,
  input  logic [DW-1:0] CMD_D,
  input  logic [CW-1:0] CMD_N,
  output logic [DW-1:0] D,
  output logic          L,
  output logic          INC,
  output logic          DEC,
  output logic          SHL,
  output logic          SHR,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR
);

  state_t        state;
  logic [2:0]    op;
  logic [DW-1:0] s;
  logic [CW-1:0] rem;
  logic [4:0]    strb;
  logic          hs, last, take;
  logic          slot_vld;
  logic [2:0]    slot_op;
  logic [DW-1:0] slot_d;
  logic [CW-1:0] slot_n;
  logic          nxt_vld;
  logic [2:0]    nxt_op;
  logic [DW-1:0] nxt_d;
  logic [CW-1:0] nxt_n;

  // Value presented on D for the current strobe, taken from the pattern register.
  function automatic logic [DW-1:0] emit(input logic [2:0] o, input logic [DW-1:0] p);
    case (o)
      OP_LOAD: return p;
      OP_SHL:  return {{(DW-1){1'b0}}, p[DW-1]};
      OP_SHR:  return {p[0], {(DW-1){1'b0}}};
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] advance(input logic [2:0] o, input logic [DW-1:0] p);
    case (o)
      OP_SHL:  return p << 1;
      OP_SHR:  return p >> 1;
      default: return p;
    endcase
  endfunction

  function automatic logic [4:0] strobe_of(input logic [2:0] o);
    case (o)
      OP_LOAD: return 5'b00001;
      OP_INC:  return 5'b00010;
      OP_DEC:  return 5'b00100;
      OP_SHL:  return 5'b01000;
      OP_SHR:  return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  assign hs   = CMD_VALID & CMD_READY;
  assign last = (state == RUN) && (rem == '0);
  assign take = (state == IDLE) || last;

`ifdef COUNTER_CMD_SEQ_QUEUE_EN
  // A command arriving on the final strobe bypasses the slot and starts directly.
  logic slot_wr, slot_rd;
  assign slot_wr   = hs & (state == RUN) & ~last;
  assign slot_rd   = last & slot_vld;
  assign CMD_READY = ~R & ((state == IDLE) | ~slot_vld);

  counter_cmd_slot #(.DW(DW), .CW(CW)) u_slot (
    .clk   (C),
    .rst   (R),
    .wr    (slot_wr),
    .rd    (slot_rd),
    .op_in (CMD_OP),
    .d_in  (CMD_D),
    .n_in  (CMD_N),
    .vld   (slot_vld),
    .op    (slot_op),
    .d     (slot_d),
    .n     (slot_n)
  );
`else
  assign slot_vld  = 1'b0;
  assign slot_op   = OP_NOP;
  assign slot_d    = '0;
  assign slot_n    = '0;
  assign CMD_READY = ~R & (state == IDLE);
`endif

  assign nxt_vld = slot_vld | hs;
  assign nxt_op  = slot_vld ? slot_op : CMD_OP;
  assign nxt_d   = slot_vld ? slot_d  : CMD_D;
  assign nxt_n   = slot_vld ? slot_n  : CMD_N;

  // rem counts strobes still to come after the one currently on the outputs.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state <= IDLE;
      op    <= OP_NOP;
      s     <= '0;
      rem   <= '0;
      strb  <= '0;
      D     <= '0;
      DONE  <= 1'b0;
      ERR   <= 1'b0;
    end else if (take) begin
      state <= IDLE;
      strb  <= '0;
      D     <= '0;
      DONE  <= 1'b0;
      ERR   <= 1'b0;
      if (nxt_vld && is_strobe_op(nxt_op)) begin
        state <= RUN;
        op    <= nxt_op;
        s     <= advance(nxt_op, nxt_d);
        D     <= emit(nxt_op, nxt_d);
        rem   <= nxt_n;
        strb  <= strobe_of(nxt_op);
        DONE  <= (nxt_n == '0);
      end else if (nxt_vld && (nxt_op > OP_SHR)) begin
        ERR   <= 1'b1;
      end
    end else begin
      rem  <= rem - 1'b1;
      s    <= advance(op, s);
      D    <= emit(op, s);
      DONE <= (rem == CW'(1));
      ERR  <= 1'b0;
    end
  end

  assign {SHR, SHL, DEC, INC, L} = strb;
  assign BUSY = (state == RUN);

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Self-checking bench: sequencer drives a behavioural 4-bit counter; results checked arithmetically.
module tb_counter_cmd_seq;

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [2:0] CMD_OP = 3'd0;
  logic [3:0] CMD_D = 4'd0;
  logic [3:0] CMD_N = 4'd0;
  logic [3:0] D;
  logic       L, INC, DEC, SHL, SHR, BUSY, DONE, ERR;
  logic [4:0] strb;
  logic [3:0] q_model;
  logic [3:0] q_exp;
  int         tests = 0;
  int         fails = 0;

  `define CHK(tag, obs, expv) \
    tests++; \
    assert (32'(obs) === 32'(expv)) else begin \
      fails++; \
      $error("FAIL %s: got %0h expected %0h", tag, 32'(obs), 32'(expv)); \
    end

  counter_cmd_seq #(.DW(4), .CW(4)) dut (
    .C(C), .R(R), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_D(CMD_D), .CMD_N(CMD_N), .D(D),
    .L(L), .INC(INC), .DEC(DEC), .SHL(SHL), .SHR(SHR),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 C = ~C;

  assign strb = {SHR, SHL, DEC, INC, L};

  // Downstream 4-bit counter reacting to the strobes.
  always @(posedge C or posedge R) begin
    if (R) q_model <= 4'd0;
    else if (L)   q_model <= D;
    else if (INC) q_model <= q_model + 4'd1;
    else if (DEC) q_model <= q_model - 4'd1;
    else if (SHL) q_model <= {q_model[2:0], D[0]};
    else if (SHR) q_model <= {D[3], q_model[3:1]};
  end

  function automatic logic [3:0] exp_d(input logic [2:0] o, input logic [3:0] dd, input int i);
    if (o == 3'd1) return dd;
    if (o == 3'd4) return (i < 4) ? {3'b000, dd[3-i]} : 4'd0;
    if (o == 3'd5) return (i < 4) ? {dd[i], 3'b000} : 4'd0;
    return 4'd0;
  endfunction

  function automatic logic [3:0] exp_q(input logic [2:0] o, input logic [3:0] q0,
                                       input logic [3:0] dd, input int k);
    logic [23:0] x;
    case (o)
      3'd1: return dd;
      3'd2: return 4'(int'(q0) + k);
      3'd3: return 4'(int'(q0) - k);
      3'd4: begin x = {q0, dd, 16'h0}; return 4'(x >> (20 - k)); end
      3'd5: begin x = {16'h0, dd, q0}; return 4'(x >> k); end
      default: return q0;
    endcase
  endfunction

  task automatic do_cmd(input logic [2:0] o, input logic [3:0] dd, input logic [3:0] nn);
    logic [4:0] sexp;
    @(negedge C);
    `CHK("ready_idle", CMD_READY, 1'b1)
    CMD_VALID = 1'b1; CMD_OP = o; CMD_D = dd; CMD_N = nn;
    @(posedge C); #1;
    CMD_VALID = 1'b0;
    if (o >= 3'd1 && o <= 3'd5) begin
      sexp = 5'(5'd1 << (o - 3'd1));
      for (int i = 0; i <= int'(nn); i++) begin
        @(negedge C);
        tests++;
        if (strb !== sexp) begin
          fails++;
          $error("FAIL strobe: got %0h expected %0h", strb, sexp);
        end
        `CHK("d_out", D, exp_d(o, dd, i))
        `CHK("done", DONE, (i == int'(nn)))
        `CHK("busy", BUSY, 1'b1)
        `CHK("err_run", ERR, 1'b0)
      end
      q_exp = exp_q(o, q_exp, dd, int'(nn) + 1);
      @(negedge C);
      `CHK("strobe_end", strb, 5'd0)
      `CHK("busy_end", BUSY, 1'b0)
      `CHK("done_end", DONE, 1'b0)
      `CHK("counter_q", q_model, q_exp)
    end else begin
      @(negedge C);
      `CHK("no_strobe", strb, 5'd0)
      `CHK("err_pulse", ERR, (o > 3'd5))
      `CHK("busy_idle", BUSY, 1'b0)
      `CHK("ready_stay", CMD_READY, 1'b1)
      @(negedge C);
      `CHK("err_one_cycle", ERR, 1'b0)
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] b2b_exp [0:4];
    logic       took;
    q_exp = 4'd0;

    // Reset state
    #2;
    `CHK("rst_strobes", strb, 5'd0)
    `CHK("rst_d", D, 4'd0)
    `CHK("rst_busy", BUSY, 1'b0)
    `CHK("rst_done", DONE, 1'b0)
    `CHK("rst_err", ERR, 1'b0)
    `CHK("rst_ready", CMD_READY, 1'b0)
    @(negedge C); @(negedge C);
    R = 1'b0;
    #1;
    `CHK("ready_after_rst", CMD_READY, 1'b1)

    // Reset in the middle of INC N=7
    @(negedge C);
    CMD_VALID = 1'b1; CMD_OP = 3'd2; CMD_N = 4'd7;
    @(posedge C); #1;
    CMD_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge C);
      tests++;
      if (strb !== 5'b00010) begin
        fails++;
        $error("FAIL mid_inc: got %0h expected 02", strb);
      end
    end
    #2 R = 1'b1;
    #1;
    `CHK("mid_rst_strobe", strb, 5'd0)
    `CHK("mid_rst_busy", BUSY, 1'b0)
    `CHK("mid_rst_done", DONE, 1'b0)
    `CHK("mid_rst_ready", CMD_READY, 1'b0)
    @(negedge C);
    R = 1'b0;
    #1;
    `CHK("mid_rel_ready", CMD_READY, 1'b1)
    q_exp = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge C);
      tests++;
      if (strb !== 5'd0) begin
        fails++;
        $error("FAIL post_rst_strobe: got %0h expected 0", strb);
      end
      tests++;
      if (DONE !== 1'b0) begin
        fails++;
        $error("FAIL post_rst_done: got %0h expected 0", DONE);
      end
    end
    `CHK("post_rst_q", q_model, 4'd0)

    // Directed commands
    do_cmd(3'd1, 4'hA, 4'd0);
    `CHK("load_a", q_model, 4'hA)
    do_cmd(3'd1, 4'h3, 4'd0);
    do_cmd(3'd2, 4'h0, 4'd4);
    `CHK("inc_to_8", q_model, 4'h8)
    do_cmd(3'd3, 4'h0, 4'd1);
    `CHK("dec_to_6", q_model, 4'h6)
    do_cmd(3'd1, 4'h0, 4'd0);
    do_cmd(3'd4, 4'b1011, 4'd3);
    `CHK("shl_pattern", q_model, 4'b1011)
    do_cmd(3'd5, 4'b0110, 4'd3);
    `CHK("shr_pattern", q_model, 4'b0110)
    do_cmd(3'd7, 4'h5, 4'd2);
    do_cmd(3'd0, 4'h5, 4'd2);
    do_cmd(3'd2, 4'h0, 4'd15);
    do_cmd(3'd4, 4'h9, 4'd6);

    // Back-to-back INC N=1 followed by DEC N=0
`ifdef COUNTER_CMD_SEQ_QUEUE_EN
    b2b_exp[0] = 5'b00010; b2b_exp[1] = 5'b00010; b2b_exp[2] = 5'b00100;
    b2b_exp[3] = 5'b00000; b2b_exp[4] = 5'b00000;
`else
    b2b_exp[0] = 5'b00010; b2b_exp[1] = 5'b00010; b2b_exp[2] = 5'b00000;
    b2b_exp[3] = 5'b00100; b2b_exp[4] = 5'b00000;
`endif
    @(negedge C);
    CMD_VALID = 1'b1; CMD_OP = 3'd2; CMD_N = 4'd1;
    @(posedge C); #1;
    CMD_OP = 3'd3; CMD_N = 4'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge C);
      tests++;
      if (strb !== b2b_exp[c]) begin
        fails++;
        $error("FAIL b2b_strobe: got %0h expected %0h", strb, b2b_exp[c]);
      end
      took = CMD_VALID & CMD_READY;
      @(posedge C); #1;
      if (took) CMD_VALID = 1'b0;
    end
    `CHK("b2b_consumed", CMD_VALID, 1'b0)
    q_exp = q_exp + 4'd1;
    @(negedge C);
    `CHK("b2b_q", q_model, q_exp)

    // Randomized commands
    for (int t = 0; t < 24; t++) begin
      do_cmd(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
